// File: rtl/brainfuck_core_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : brainfuck_core_pkg
// Brief    : Opcode bytes, opcode-class bit positions and FSM states.
// Revision : 1.0
// ============================================================================
package brainfuck_core_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_LOOP  = 8'h5B;
    localparam logic [7:0] OP_END   = 8'h5D;
    localparam logic [7:0] OP_NUL   = 8'h00;

    // Bit positions inside the decoded class vector; all-zero means no-op.
    localparam int CLS_INC   = 0;
    localparam int CLS_DEC   = 1;
    localparam int CLS_RIGHT = 2;
    localparam int CLS_LEFT  = 3;
    localparam int CLS_OUT   = 4;
    localparam int CLS_LOOP  = 5;
    localparam int CLS_END   = 6;
    localparam int CLS_NUL   = 7;
    localparam int CLS_W     = 8;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC   = 3'd1,
        S_SFETCH = 3'd2,
        S_SFWD   = 3'd3,
        S_BFETCH = 3'd4,
        S_SBACK  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/brainfuck_core_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bf_decode
// Brief    : Combinational instruction byte to one-hot opcode class.
// Revision : 1.0
// ============================================================================
module bf_decode
    import brainfuck_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] code,
    output logic [CLS_W-1:0]  op_class
);

    always_comb begin
        op_class = '0;
        case (code)
            OP_INC:   op_class[CLS_INC]   = 1'b1;
            OP_DEC:   op_class[CLS_DEC]   = 1'b1;
            OP_RIGHT: op_class[CLS_RIGHT] = 1'b1;
            OP_LEFT:  op_class[CLS_LEFT]  = 1'b1;
            OP_OUT:   op_class[CLS_OUT]   = 1'b1;
            OP_LOOP:  op_class[CLS_LOOP]  = 1'b1;
            OP_END:   op_class[CLS_END]   = 1'b1;
            OP_NUL:   op_class[CLS_NUL]   = 1'b1;
            default:  op_class = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/brainfuck_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : brainfuck_core
// Brief    : Multi-cycle Brainfuck interpreter; external code ROM, data RAM.
// Revision : 1.0
// ============================================================================
module brainfuck_core
    import brainfuck_core_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int DEPTH_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] code_out,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr_code,
    output logic [ADDR_W-1:0] addr_array,
    output logic [DATA_W-1:0] data_out,
    output logic              write_rq,
    output logic              probe
);

    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_nx;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_nx;
    logic [DEPTH_W-1:0]  depth;
    logic [DEPTH_W-1:0]  depth_nx;
    logic [CLS_W-1:0]    cls;
    logic                cell_zero;
    logic                depth_one;
    logic                pc_zero;

    bf_decode #(
        .DATA_W   (DATA_W)
    ) u_decode (
        .code     (code_out),
        .op_class (cls)
    );

    assign addr_code  = pc;
    assign addr_array = ptr;
    assign cell_zero  = (data_in == '0);
    assign depth_one  = (depth == DEPTH_ONE);
    assign pc_zero    = (pc == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            pc    <= '0;
            ptr   <= '0;
            depth <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ptr   <= ptr_nx;
            depth <= depth_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ptr_nx   = ptr;
        depth_nx = depth;
        data_out = data_in;
        write_rq = 1'b0;
        probe    = 1'b0;
        case (state)
            S_FETCH: state_nx = S_EXEC;

            S_EXEC: begin
                state_nx = S_FETCH;
                pc_nx    = pc + 1'b1;
                if (cls[CLS_NUL]) begin
                    state_nx = S_HALT;
                    pc_nx    = pc;
                end else if (cls[CLS_INC]) begin
                    data_out = data_in + 1'b1;
                    write_rq = 1'b1;
                end else if (cls[CLS_DEC]) begin
                    data_out = data_in - 1'b1;
                    write_rq = 1'b1;
                end else if (cls[CLS_RIGHT]) begin
                    ptr_nx = ptr + 1'b1;
                end else if (cls[CLS_LEFT]) begin
                    ptr_nx = ptr - 1'b1;
                end else if (cls[CLS_OUT]) begin
                    probe = 1'b1;
                end else if (cls[CLS_LOOP] && cell_zero) begin
                    depth_nx = DEPTH_ONE;
                    state_nx = S_SFETCH;
                end else if (cls[CLS_END] && !cell_zero) begin
                    depth_nx = DEPTH_ONE;
                    pc_nx    = pc - 1'b1;
                    state_nx = S_BFETCH;
                end
            end

            S_SFETCH: state_nx = S_SFWD;

            // A terminator inside a forward scan means the '[' never closes.
            S_SFWD: begin
                state_nx = S_SFETCH;
                pc_nx    = pc + 1'b1;
                if (cls[CLS_NUL]) begin
                    state_nx = S_HALT;
                    pc_nx    = pc;
                end else if (cls[CLS_LOOP]) begin
                    depth_nx = depth + 1'b1;
                end else if (cls[CLS_END]) begin
                    depth_nx = depth - 1'b1;
                    if (depth_one) begin
                        state_nx = S_FETCH;
                    end
                end
            end

            S_BFETCH: state_nx = S_SBACK;

            // The match check wins over the start-of-program check at pc 0.
            S_SBACK: begin
                state_nx = S_BFETCH;
                pc_nx    = pc - 1'b1;
                if (cls[CLS_LOOP] && depth_one) begin
                    depth_nx = depth - 1'b1;
                    pc_nx    = pc + 1'b1;
                    state_nx = S_FETCH;
                end else begin
                    if (cls[CLS_LOOP]) begin
                        depth_nx = depth - 1'b1;
                    end else if (cls[CLS_END]) begin
                        depth_nx = depth + 1'b1;
                    end
                    if (pc_zero) begin
                        state_nx = S_HALT;
                        pc_nx    = pc;
                    end
                end
            end

            S_HALT: state_nx = S_HALT;

            default: state_nx = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_brainfuck_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_brainfuck_core
// Brief    : Table, directed and random programs against an interpreter model.
// Revision : 1.0
// ============================================================================
module tb_brainfuck_core;

    localparam int LIMIT = 3000;

    typedef struct {
        int t;
        int kind;
        int addr;
        int val;
    } ev_t;

    typedef struct {
        string      prog;
        logic [7:0] cell0;
        int         pc;
        int         ptr;
        int         nwr;
        int         npr;
        int         cell_addr;
        int         cell_val;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_req = 1'b0;
    logic [7:0] code_out;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [8:0] addr_code;
    logic [8:0] addr_array;
    logic       write_rq;
    logic       probe;

    logic [7:0] rom      [512];
    logic [7:0] ram      [512];
    logic [7:0] init_ram [512];
    logic [7:0] mram     [512];

    ev_t exp_q[$];
    ev_t got_q[$];

    int checks   = 0;
    int failures = 0;

    brainfuck_core dut (
        .clk        (clk),
        .reset      (reset),
        .code_out   (code_out),
        .data_in    (data_in),
        .addr_code  (addr_code),
        .addr_array (addr_array),
        .data_out   (data_out),
        .write_rq   (write_rq),
        .probe      (probe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) code_out <= rom[addr_code];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_ram[i];
        end else if (write_rq) begin
            ram[addr_array] <= data_out;
        end
    end

    assign data_in = ram[addr_array];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic load_prog(input string s);
        for (int i = 0; i < 512; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 512; i++) init_ram[i] = 8'h00;
    endtask

    // Holds reset, loads RAM, releases reset on a falling edge; cycle 0 is the first FETCH.
    task automatic start_run();
        reset    = 1'b0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic run(input int ncyc);
        start_run();
        got_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (write_rq === 1'b1) got_q.push_back('{c, 1, int'(addr_array), int'(data_out)});
            if (probe === 1'b1)    got_q.push_back('{c, 2, int'(addr_code), 0});
            @(negedge clk);
            #1;
        end
    endtask

    // Instruction-level interpreter: each step (fetch+execute or one scanned byte) costs 2 cycles.
    task automatic model_run(output int fpc, output int fptr, output int ht, output bit ok);
        int pc, ptr, t, d;
        logic [7:0] op;
        pc = 0; ptr = 0; t = 0; ok = 1'b0; fpc = 0; fptr = 0; ht = 0;
        exp_q.delete();
        for (int i = 0; i < 512; i++) mram[i] = init_ram[i];
        while (t < LIMIT) begin
            op = rom[pc];
            if (op == 8'h00) begin
                ht = t + 1; fpc = pc; fptr = ptr; ok = 1'b1;
                return;
            end
            case (op)
                8'h2B: begin
                    mram[ptr] = mram[ptr] + 8'd1;
                    exp_q.push_back('{t + 1, 1, ptr, int'(mram[ptr])});
                end
                8'h2D: begin
                    mram[ptr] = mram[ptr] - 8'd1;
                    exp_q.push_back('{t + 1, 1, ptr, int'(mram[ptr])});
                end
                8'h3E: ptr = (ptr + 1) % 512;
                8'h3C: ptr = (ptr + 511) % 512;
                8'h2E: exp_q.push_back('{t + 1, 2, pc, 0});
                default: ;
            endcase
            t += 2;
            if (op == 8'h5B && mram[ptr] == 8'h00) begin
                d = 1;
                while (d != 0) begin
                    pc = (pc + 1) % 512;
                    op = rom[pc];
                    t += 2;
                    if (op == 8'h00) begin
                        ht = t - 1; fpc = pc; fptr = ptr; ok = 1'b1;
                        return;
                    end
                    if (op == 8'h5B) d++;
                    else if (op == 8'h5D) d--;
                    if (t >= LIMIT) return;
                end
                pc = (pc + 1) % 512;
            end else if (op == 8'h5D && mram[ptr] != 8'h00) begin
                d  = 1;
                pc = (pc + 511) % 512;
                forever begin
                    op = rom[pc];
                    t += 2;
                    if (op == 8'h5D) d++;
                    else if (op == 8'h5B) begin
                        d--;
                        if (d == 0) break;
                    end
                    if (pc == 0) begin
                        ht = t - 1; fpc = 0; fptr = ptr; ok = 1'b1;
                        return;
                    end
                    pc = pc - 1;
                    if (t >= LIMIT) return;
                end
                pc = pc + 1;
            end else begin
                pc = (pc + 1) % 512;
            end
        end
    endtask

    task automatic compare_model(input string name, input int fpc, input int fptr);
        int n;
        int bad;
        check({name, " pc"}, 32'(addr_code), fpc);
        check({name, " ptr"}, 32'(addr_array), fptr);
        check({name, " events"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s ev%0d cycle*4+kind", name, i),
                  got_q[i].t * 4 + got_q[i].kind, exp_q[i].t * 4 + exp_q[i].kind);
            check($sformatf("%s ev%0d addr*256+val", name, i),
                  got_q[i].addr * 256 + got_q[i].val, exp_q[i].addr * 256 + exp_q[i].val);
        end
        bad = 0;
        for (int i = 0; i < 512; i++) if (ram[i] !== mram[i]) bad++;
        check({name, " ram cells differing"}, bad, 0);
    endtask

    vec_t tbl[8];

    initial begin
        int fpc, fptr, ht, nwr, npr;
        bit ok;
        string s;
        string alpha;

        tbl[0] = '{"+++.",   8'h00, 4, 0,   3, 1, 0,   3};
        tbl[1] = '{"><<-",   8'h00, 4, 511, 1, 0, 511, 255};
        tbl[2] = '{"[+].",   8'h00, 4, 0,   0, 1, 0,   0};
        tbl[3] = '{"++[-].", 8'h00, 6, 0,   4, 1, 0,   0};
        tbl[4] = '{"[[]",    8'h00, 3, 0,   0, 0, 0,   0};
        tbl[5] = '{"+]",     8'h00, 0, 0,   1, 0, 0,   1};
        tbl[6] = '{"[",      8'h07, 1, 0,   0, 0, 0,   7};
        tbl[7] = '{",-",     8'h00, 2, 0,   1, 0, 0,   255};

        // Reset state, with a known cell so the data_out mirror is observable.
        load_prog("+");
        clear_ram();
        init_ram[0] = 8'h5A;
        reset    = 1'b0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("reset addr_code", 32'(addr_code), 0);
        check("reset addr_array", 32'(addr_array), 0);
        check("reset write_rq", 32'(write_rq), 0);
        check("reset probe", 32'(probe), 0);
        check("reset data_out mirror", 32'(data_out), 32'h5A);

        foreach (tbl[k]) begin
            load_prog(tbl[k].prog);
            clear_ram();
            init_ram[0] = tbl[k].cell0;
            model_run(fpc, fptr, ht, ok);
            run(ht + 10);
            nwr = 0; npr = 0;
            foreach (got_q[i]) begin
                if (got_q[i].kind == 1) nwr++;
                else npr++;
            end
            s = {"tbl '", tbl[k].prog, "'"};
            check({s, " final pc"}, 32'(addr_code), tbl[k].pc);
            check({s, " final ptr"}, 32'(addr_array), tbl[k].ptr);
            check({s, " writes"}, nwr, tbl[k].nwr);
            check({s, " probes"}, npr, tbl[k].npr);
            check({s, " cell"}, 32'(ram[tbl[k].cell_addr]), tbl[k].cell_val);
            compare_model(s, fpc, fptr);
        end

        // Reset in the middle of a forward scan of an unmatched bracket.
        load_prog("[[]");
        clear_ram();
        start_run();
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        check("midscan pc before reset", 32'(addr_code), 2);
        reset = 1'b0;
        #1;
        check("midscan pc after async reset", 32'(addr_code), 0);

        // Reset during the write cycle drops the write.
        load_prog("+");
        clear_ram();
        start_run();
        @(negedge clk);
        #1;
        check("midwrite write_rq before reset", 32'(write_rq), 1);
        reset = 1'b0;
        #1;
        check("midwrite write_rq after async reset", 32'(write_rq), 0);
        @(negedge clk);
        #1;
        check("midwrite cell unchanged", 32'(ram[0]), 0);

        // Random programs over the full alphabet.
        alpha = "++-><.[],";
        for (int r = 0; r < 20; r++) begin
            ok = 1'b0;
            for (int tries = 0; tries < 20 && !ok; tries++) begin
                int len;
                for (int i = 0; i < 512; i++) rom[i] = 8'h00;
                len = $urandom_range(4, 24);
                for (int i = 0; i < len; i++) rom[i] = alpha[$urandom_range(0, alpha.len() - 1)];
                clear_ram();
                for (int i = 0; i < 4; i++) init_ram[i] = 8'($urandom_range(0, 3));
                model_run(fpc, fptr, ht, ok);
            end
            if (ok) begin
                run(ht + 10);
                compare_model($sformatf("rand%0d", r), fpc, fptr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
